// File: rtl/cpu_pkg.sv
// Shared datapath definitions: register function codes, byte selects and widths.
package cpu_pkg;

  localparam logic [1:0] FS_CLEAR = 2'b00;
  localparam logic [1:0] FS_LOAD  = 2'b01;
  localparam logic [1:0] FS_DEC   = 2'b10;
  localparam logic [1:0] FS_INC   = 2'b11;

  localparam logic LH_LOW  = 1'b0;
  localparam logic LH_HIGH = 1'b1;

  localparam int IR_W   = 16;
  localparam int DATA_W = 8;

endpackage

// File: rtl/instruction_register_if.sv
// Control/data bundle of the instruction register; master drives, slave returns irout.
interface instruction_register_if import cpu_pkg::*; ();

  logic              enable;
  logic [1:0]        funsel;
  logic              lh;
  logic [DATA_W-1:0] data;
  logic [IR_W-1:0]   irout;

  modport master (output enable, funsel, lh, data, input irout);
  modport slave  (input enable, funsel, lh, data, output irout);

endinterface

// File: rtl/instruction_register_register.sv
// Generic N-bit function register: clear, load, decrement, increment (modulo 2^N).
module register import cpu_pkg::*; #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [1:0]   funsel,
  input  logic [N-1:0] load,
  output logic [N-1:0] Q_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Q_out <= '0;
    end else if (enable) begin
      case (funsel)
        FS_CLEAR: Q_out <= '0;
        FS_LOAD:  Q_out <= load;
        FS_DEC:   Q_out <= Q_out - N'(1);
        FS_INC:   Q_out <= Q_out + N'(1);
        default:  Q_out <= Q_out;
      endcase
    end
  end

endmodule

// File: rtl/instruction_register.sv
// 16-bit instruction register loaded a byte at a time; all state lives in the sub-register.
module instruction_register import cpu_pkg::*; (
  input  logic                   clk,
  input  logic                   rst,
  instruction_register_if.slave  ir_bus
);

  logic [IR_W-1:0] irout_q;
  logic [IR_W-1:0] load_word;

  // The untouched byte is taken from the current contents so a LOAD only replaces one half.
  always_comb begin
    load_word = irout_q;
    if (ir_bus.lh == LH_HIGH)
      load_word = {ir_bus.data, irout_q[DATA_W-1:0]};
    else
      load_word = {irout_q[IR_W-1:DATA_W], ir_bus.data};
  end

  register #(.N(IR_W)) u_ir_reg (
    .clk    (clk),
    .rst    (rst),
    .enable (ir_bus.enable),
    .funsel (ir_bus.funsel),
    .load   (load_word),
    .Q_out  (irout_q)
  );

  assign ir_bus.irout = irout_q;

endmodule

// File: tb/tb_instruction_register.sv
// Self-checking bench for instruction_register and the generic register sub-module.
module tb_instruction_register;
  import cpu_pkg::*;

  typedef struct {
    logic        en;
    logic [1:0]  fs;
    logic        lh;
    logic [7:0]  data;
    logic [15:0] exp;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_register_if ir_if ();
  instruction_register dut (.clk(clk), .rst(rst), .ir_bus(ir_if));

  logic       s_en;
  logic [1:0] s_fs;
  logic [7:0] s_load;
  logic [7:0] s_q;
  register #(.N(8)) u_reg8 (
    .clk(clk), .rst(rst), .enable(s_en), .funsel(s_fs), .load(s_load), .Q_out(s_q)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] sb_q[$];
  logic [7:0]  sb8_q[$];
  vec_t vecs[$];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    logic [15:0] e;
    @(negedge clk);
    ir_if.enable = v.en;
    ir_if.funsel = v.fs;
    ir_if.lh     = v.lh;
    ir_if.data   = v.data;
    sb_q.push_back(v.exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e = sb_q.pop_front();
      check16(v.name, ir_if.irout, e);
    end
  endtask

  task automatic drive8(input string name, input logic en, input logic [1:0] fs,
                        input logic [7:0] ld, input logic [7:0] exp);
    logic [7:0] e;
    @(negedge clk);
    s_en = en; s_fs = fs; s_load = ld;
    sb8_q.push_back(exp);
    @(posedge clk);
    #1;
    e = sb8_q.pop_front();
    check8(name, s_q, e);
  endtask

  function automatic vec_t mk(input logic en, input logic [1:0] fs, input logic lh,
                              input logic [7:0] d, input logic [15:0] exp, input string name);
    vec_t v;
    v.en = en; v.fs = fs; v.lh = lh; v.data = d; v.exp = exp; v.name = name;
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    ir_if.enable = 1'b0; ir_if.funsel = FS_CLEAR; ir_if.lh = LH_LOW; ir_if.data = 8'h00;
    s_en = 1'b0; s_fs = FS_CLEAR; s_load = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check16("reset_ir", ir_if.irout, 16'h0000);
    check8("reset_reg8", s_q, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Byte loads, inc/dec with carries, wrap-around, hold, clear
    vecs.push_back(mk(1, FS_LOAD, LH_HIGH, 8'h95, 16'h9500, "load_hi_95"));
    vecs.push_back(mk(1, FS_LOAD, LH_LOW,  8'h01, 16'h9501, "load_lo_01"));
    vecs.push_back(mk(1, FS_LOAD, LH_HIGH, 8'hA0, 16'hA001, "load_hi_keep_lo"));
    vecs.push_back(mk(1, FS_LOAD, LH_HIGH, 8'h95, 16'h9501, "reload_hi_95"));
    vecs.push_back(mk(1, FS_INC,  LH_LOW,  8'hEE, 16'h9502, "inc1"));
    vecs.push_back(mk(1, FS_INC,  LH_HIGH, 8'h33, 16'h9503, "inc2_lh_ignored"));
    vecs.push_back(mk(1, FS_INC,  LH_LOW,  8'h00, 16'h9504, "inc3"));
    vecs.push_back(mk(1, FS_DEC,  LH_HIGH, 8'h77, 16'h9503, "dec1"));
    vecs.push_back(mk(1, FS_DEC,  LH_LOW,  8'h00, 16'h9502, "dec2"));
    vecs.push_back(mk(1, FS_LOAD, LH_HIGH, 8'h00, 16'h0002, "load_hi_00"));
    vecs.push_back(mk(1, FS_LOAD, LH_LOW,  8'hFF, 16'h00FF, "load_lo_ff"));
    vecs.push_back(mk(1, FS_INC,  LH_LOW,  8'h00, 16'h0100, "inc_byte_carry"));
    vecs.push_back(mk(1, FS_DEC,  LH_LOW,  8'h00, 16'h00FF, "dec_byte_borrow"));
    vecs.push_back(mk(1, FS_CLEAR, LH_HIGH, 8'h5A, 16'h0000, "clear"));
    vecs.push_back(mk(1, FS_DEC,  LH_LOW,  8'h00, 16'hFFFF, "dec_wrap"));
    vecs.push_back(mk(1, FS_INC,  LH_HIGH, 8'h00, 16'h0000, "inc_wrap"));
    vecs.push_back(mk(1, FS_LOAD, LH_HIGH, 8'h95, 16'h9500, "load_hi_95b"));
    vecs.push_back(mk(1, FS_LOAD, LH_LOW,  8'h01, 16'h9501, "load_lo_01b"));
    for (int i = 0; i < 8; i++) begin
      logic [2:0] sel;
      sel = 3'(i);
      vecs.push_back(mk(1'b0, sel[1:0], sel[2], 8'($urandom_range(0, 255)), 16'h9501,
                        $sformatf("hold_%0d", i)));
    end
    vecs.push_back(mk(1, FS_CLEAR, LH_LOW, 8'hFF, 16'h0000, "clear_after_hold"));

    foreach (vecs[i]) drive(vecs[i]);

    // Asynchronous reset mid-cycle, then held across edges with a pending LOAD
    drive(mk(1, FS_LOAD, LH_HIGH, 8'h12, 16'h1200, "pre_rst_hi"));
    drive(mk(1, FS_LOAD, LH_LOW,  8'h34, 16'h1234, "pre_rst_lo"));
    @(negedge clk);
    ir_if.enable = 1'b1; ir_if.funsel = FS_LOAD; ir_if.lh = LH_HIGH; ir_if.data = 8'hFF;
    #2;
    rst = 1'b1;
    #1;
    check16("async_rst_immediate", ir_if.irout, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check16($sformatf("rst_hold_%0d", k), ir_if.irout, 16'h0000);
    end
    @(negedge clk);
    rst = 1'b0;
    ir_if.enable = 1'b0;
    drive(mk(1, FS_LOAD, LH_LOW, 8'hC3, 16'h00C3, "post_rst_load"));

    // Generic 8-bit register
    drive8("r8_load",  1, FS_LOAD,  8'h95, 8'h95);
    drive8("r8_dec1",  1, FS_DEC,   8'h00, 8'h94);
    drive8("r8_dec2",  1, FS_DEC,   8'h00, 8'h93);
    drive8("r8_dec3",  1, FS_DEC,   8'h00, 8'h92);
    drive8("r8_dec4",  1, FS_DEC,   8'h00, 8'h91);
    drive8("r8_hold",  0, FS_LOAD,  8'h3C, 8'h91);
    drive8("r8_clear", 1, FS_CLEAR, 8'hAA, 8'h00);
    drive8("r8_dec_wrap", 1, FS_DEC, 8'h00, 8'hFF);
    drive8("r8_inc_wrap", 1, FS_INC, 8'h00, 8'h00);

    if (sb_q.size() != 0 || sb8_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0", sb_q.size(), sb8_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
